mem_xfer_seq: RTL
=================

// Module: mem_xfer_seq
// PURPOSE
//  Executes the 8-bit memory control words produced by the MEM control-word decoder.
//  Each word is one transfer between the data memory and the A, B or R registers.
//  Sits between the decoder and the data RAM port. It runs a req/ack memory handshake,
//  then returns register-load or clear strobes to the datapath.
// PARAMETERS
//  DW       4   data width (A/B/R registers, memory word)
//  AW       4   memory address width
//  TIMEOUT  15  cycles to wait for mem_ack before aborting (1..2**CW-1)
//  CW       4   width of the timeout counter
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  ctrl_valid  in   1   ctrl/addr hold a command
//  ctrl        in   8   control word from decoder
//  addr        in   AW  memory address for this command
//  ctrl_ready  out  1   sequencer accepts a command this cycle
//  reg_a       in   DW  current A register value
//  reg_b       in   DW  current B register value
//  reg_r       in   DW  current R (ALU result) value
//  ld_a        out  1   1-cycle strobe: load ld_data into A
//  ld_b        out  1   1-cycle strobe: load ld_data into B
//  clr_ab      out  1   1-cycle strobe: clear A and B
//  ld_data     out  DW  data captured from memory
//  mem_req     out  1   memory request, held until ack or timeout
//  mem_we      out  1   1 = write, 0 = read (valid while mem_req)
//  mem_addr    out  AW  latched address
//  mem_wdata   out  DW  latched write data
//  mem_rdata   in   DW  read data, valid in the cycle mem_ack=1
//  mem_ack     in   1   memory completes the access
//  busy        out  1   state != IDLE
//  err         out  1   sticky; set on timeout or illegal ctrl, cleared on next accept
// BEHAVIOUR
//  - Reset values: all outputs 0, except ctrl_ready=1. State IDLE, counter 0, ld_data 0.
//  - Accept: a command is accepted when ctrl_valid & ctrl_ready. ctrl_ready = (state==IDLE).
//    ctrl, addr and the selected register value are latched at accept.
//  - Decode at accept (other codes are illegal):
//    00h: NOP, no memory access. 04h: read -> A. 05h: read -> B. 0Fh: clear A and B.
//    06h: write A. 07h: write B. 70h: write R.
//  - NOP: stays IDLE. No strobe, no busy.
//  - 0Fh: go to DONE. clr_ab pulses the next cycle. No memory access.
//  - Illegal code: err <= 1. Treated as NOP.
//  - Read/write: state goes IDLE -> REQ. mem_req=1 from the cycle after accept.
//    mem_we, mem_addr and mem_wdata are constant during REQ.
//  - REQ exit on ack: when mem_ack=1, drop mem_req the next cycle and go to DONE.
//    For a read, ld_data <= mem_rdata in the ack cycle.
//  - REQ exit on timeout: the counter increments each REQ cycle without ack.
//    At TIMEOUT it drops mem_req, sets err, issues no strobe and returns to IDLE.
//  - DONE lasts 1 cycle and drives exactly one of ld_a / ld_b / clr_ab. Writes drive no strobe.
//    Next state is IDLE.
//  - Latency with 0-wait memory: accept at T, mem_req at T+1, ack at T+1,
//    strobe at T+2, ctrl_ready at T+3.
//  - mem_ack outside REQ is ignored.
//  - ctrl_valid during busy is ignored; upstream holds it until ready.
//  - err clears on the next accepted command, including NOP. It is set again if that command fails.
//  - rst_n assert mid-transfer: mem_req drops immediately (async). Nothing is strobed.
//  - Counter saturates and is cleared on REQ entry.
// STRUCTURE
//  - Shared package mem_ctrl_pkg:
//    - ctrl codes: CTRL_NOP, CTRL_LD_A, CTRL_LD_B, CTRL_CLR, CTRL_ST_A, CTRL_ST_B, CTRL_ST_R
//    - state encoding: IDLE, REQ, DONE
//    - same package is used by the decoder
//  - One flat module, single FSM with registered outputs. No sub-module.
// TESTING
//  - Read, 0-wait: ctrl=04h, addr=3, ack same cycle with rdata=9 -> ld_a=1 at T+2, ld_data=9.
//    mem_we=0, mem_addr=3.
//  - Write, 3-wait: ctrl=70h, reg_r=Ah -> mem_req, mem_we=1, wdata=A held for 3 cycles.
//    No strobe, err=0.
//  - Timeout: ctrl=05h, no ack -> mem_req high 15 cycles, then err=1, no ld_b, ready=1.
//    Next NOP clears err.
//  - Clear and illegal: ctrl=0Fh -> clr_ab pulses once, mem_req never rises.
//    ctrl=33h -> err=1, busy stays 0.
//  - Reset mid-REQ: deassert rst_n during wait -> mem_req=0 asynchronously, outputs at reset values.
//    Stray ack afterwards is ignored.
//  - Back-to-back: ctrl_valid held with 04h, 06h -> second command accepted only when ready=1.
//    Ordering is preserved.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared MEM control-word definitions: command codes, sequencer states and a decode helper.
// Also used by the MEM control-word decoder.
package mem_ctrl_pkg;

  localparam logic [7:0] CTRL_NOP  = 8'h00;
  localparam logic [7:0] CTRL_LD_A = 8'h04;
  localparam logic [7:0] CTRL_LD_B = 8'h05;
  localparam logic [7:0] CTRL_CLR  = 8'h0F;
  localparam logic [7:0] CTRL_ST_A = 8'h06;
  localparam logic [7:0] CTRL_ST_B = 8'h07;
  localparam logic [7:0] CTRL_ST_R = 8'h70;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    K_NOP = 3'd0,
    K_RD  = 3'd1,
    K_WR  = 3'd2,
    K_CLR = 3'd3,
    K_ILL = 3'd4
  } kind_e;

  // Classify a control word into the kind of transfer it requests.
  function automatic kind_e ctrl_kind(input logic [7:0] c);
    case (c)
      CTRL_NOP:                       ctrl_kind = K_NOP;
      CTRL_LD_A, CTRL_LD_B:           ctrl_kind = K_RD;
      CTRL_ST_A, CTRL_ST_B, CTRL_ST_R: ctrl_kind = K_WR;
      CTRL_CLR:                       ctrl_kind = K_CLR;
      default:                        ctrl_kind = K_ILL;
    endcase
  endfunction

endpackage

// File: rtl/mem_xfer_seq.sv
// Memory transfer sequencer: runs one req/ack access per MEM control word and
// returns a single-cycle load or clear strobe to the datapath.
module mem_xfer_seq
  import mem_ctrl_pkg::*;
#(
  parameter int DW      = 4,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrl_valid,
  input  logic [7:0]    ctrl,
  input  logic [AW-1:0] addr,
  output logic          ctrl_ready,
  input  logic [DW-1:0] reg_a,
  input  logic [DW-1:0] reg_b,
  input  logic [DW-1:0] reg_r,
  output logic          ld_a,
  output logic          ld_b,
  output logic          clr_ab,
  output logic [DW-1:0] ld_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err
);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ctrl_ready_q, ctrl_ready_d;
  logic          ld_a_q, ld_a_d;
  logic          ld_b_q, ld_b_d;
  logic          clr_ab_q, clr_ab_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          accept_s;
  logic          timeout_s;
  kind_e         kind_in_s;
  logic [7:0]    ctrl_eff_s;
  logic [DW-1:0] wsel_s;

  assign accept_s  = ctrl_valid & ctrl_ready_q;
  assign kind_in_s = ctrl_kind(ctrl);
  // Timeout fires on the last allowed REQ cycle only if that cycle has no ack.
  assign timeout_s = (state_q == REQ) & ~mem_ack & (cnt_q == TO_LAST);
  // In IDLE the strobe decision comes straight from the incoming word (clear goes IDLE->DONE).
  assign ctrl_eff_s = (state_q == IDLE) ? ctrl : ctrl_q;

  // Write-data select for the incoming command.
  always_comb begin
    case (ctrl)
      CTRL_ST_A: wsel_s = reg_a;
      CTRL_ST_B: wsel_s = reg_b;
      CTRL_ST_R: wsel_s = reg_r;
      default:   wsel_s = {DW{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (kind_in_s)
            K_RD, K_WR: state_d = REQ;
            K_CLR:      state_d = DONE;
            default:    state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
        end else if (timeout_s) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; every port is driven from a flop.
  always_comb begin
    ctrl_d       = ctrl_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    err_d        = err_q;
    ld_data_d    = ld_data_q;
    cnt_d        = cnt_q;

    if (accept_s) begin
      ctrl_d      = ctrl;
      mem_addr_d  = addr;
      mem_wdata_d = wsel_s;
      mem_we_d    = (kind_in_s == K_WR);
      err_d       = (kind_in_s == K_ILL);
    end else if (timeout_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (state_d != REQ) begin
      mem_we_d = 1'b0;
    end else begin
      mem_we_d = mem_we_d;
    end

    // Counter is held at zero outside REQ, so it starts cleared on every REQ entry.
    if (state_q != REQ) begin
      cnt_d = {CW{1'b0}};
    end else if (!mem_ack && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    if ((state_q == REQ) && mem_ack && (ctrl_kind(ctrl_q) == K_RD)) begin
      ld_data_d = mem_rdata;
    end else begin
      ld_data_d = ld_data_q;
    end

    ctrl_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    mem_req_d    = (state_d == REQ);
    ld_a_d       = (state_d == DONE) && (ctrl_eff_s == CTRL_LD_A);
    ld_b_d       = (state_d == DONE) && (ctrl_eff_s == CTRL_LD_B);
    clr_ab_d     = (state_d == DONE) && (ctrl_eff_s == CTRL_CLR);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= 8'h00;
      cnt_q        <= {CW{1'b0}};
      ctrl_ready_q <= 1'b1;
      ld_a_q       <= 1'b0;
      ld_b_q       <= 1'b0;
      clr_ab_q     <= 1'b0;
      ld_data_q    <= {DW{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      cnt_q        <= cnt_d;
      ctrl_ready_q <= ctrl_ready_d;
      ld_a_q       <= ld_a_d;
      ld_b_q       <= ld_b_d;
      clr_ab_q     <= clr_ab_d;
      ld_data_q    <= ld_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign ctrl_ready = ctrl_ready_q;
  assign ld_a       = ld_a_q;
  assign ld_b       = ld_b_q;
  assign clr_ab     = clr_ab_q;
  assign ld_data    = ld_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
